// File: rtl/prbs_serdes_bert.sv
// prbs_serdes_bert: PRBS7/15/23/31 serial generator with self-synchronising checker, lock FSM and BER counters.
module prbs_serdes_bert #(
    parameter int WORD_W     = 32,
    parameter int CNT_W      = 64,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4
) (
    input  logic             CLKBit,
    input  logic             RSTn,
    input  logic             enable,
    input  logic [1:0]       prbs_sel,
    input  logic             err_inject,
    input  logic             clear,
    output logic             ser_out,
    input  logic             des_in,
    output logic             word_strobe,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);
    localparam int BW = $clog2(WORD_W);
    localparam int EW = $clog2(WORD_W + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    function automatic logic tap(input logic [30:0] s, input logic [1:0] p);
        return p == 2'd0 ? s[6] ^ s[5] : p == 2'd1 ? s[14] ^ s[13] :
               p == 2'd2 ? s[22] ^ s[17] : s[30] ^ s[27];
    endfunction

    logic [1:0]        poly;
    logic [30:0]       lfsr, hist;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] des_sr, err_sr;
    logic [WORD_W-1:0] word_des, word_err;
    logic [EW-1:0]     pop, werr;
    logic [7:0]        good, good_d;
    logic [CNT_W:0]    err_sum;
    logic [CNT_W-1:0]  err_next, word_next;
    logic              tx_fb, rx_err, accum;
    state_t            state, state_d;

    assign tx_fb       = tap(lfsr, poly);
    assign rx_err      = des_in ^ tap(hist, poly);
    assign word_strobe = enable && bit_cnt == BW'(WORD_W - 1);
    assign word_des    = {des_sr, des_in};
    assign word_err    = {err_sr, rx_err};
    assign locked      = state == LOCKED;
    assign err_sum     = {1'b0, err_count} + {{(CNT_W + 1 - EW){1'b0}}, werr};
    assign err_next    = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    assign word_next   = &word_count ? word_count : word_count + CNT_W'(1);

    // An all-zero word means a dead line, which the self-synchronising check alone would miss
    always_comb begin
        pop = '0;
        for (int i = 0; i < WORD_W; i++) pop = pop + EW'(word_err[i]);
        werr = word_des == '0 ? EW'(WORD_W) : pop;
    end

    always_comb begin
        state_d = state;
        good_d  = good;
        accum   = 1'b0;
        if (word_strobe) begin
            if (state == SEARCH) begin
                good_d  = werr == '0 ? good + 8'd1 : 8'd0;
                state_d = werr == '0 && good + 8'd1 == 8'(LOCK_CNT) ? LOCKED : SEARCH;
                if (state_d == LOCKED) good_d = 8'd0;
            end else if (werr >= EW'(UNLOCK_ERR)) begin
                state_d = SEARCH;
                good_d  = 8'd0;
            end else begin
                accum = 1'b1;
            end
        end
    end

    always_ff @(posedge CLKBit or negedge RSTn) begin
        if (!RSTn) begin
            state <= SEARCH;
            good  <= 8'd0;
        end else begin
            state <= state_d;
            good  <= good_d;
        end
    end

    // Reseeding on a polynomial change keeps the shorter LFSRs out of the all-zero state
    always_ff @(posedge CLKBit or negedge RSTn) begin
        if (!RSTn) begin
            poly       <= 2'd0;
            lfsr       <= '1;
            hist       <= '0;
            bit_cnt    <= '0;
            des_sr     <= '0;
            err_sr     <= '0;
            ser_out    <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (!enable && prbs_sel != poly) begin
                poly <= prbs_sel;
                lfsr <= '1;
            end
            if (enable) begin
                lfsr    <= {lfsr[29:0], tx_fb};
                ser_out <= tx_fb ^ err_inject;
                hist    <= {hist[29:0], des_in};
                des_sr  <= word_des[WORD_W-2:0];
                err_sr  <= word_err[WORD_W-2:0];
                bit_cnt <= word_strobe ? '0 : bit_cnt + BW'(1);
            end
            if (clear) begin
                err_count  <= '0;
                word_count <= '0;
            end else if (accum) begin
                err_count  <= err_next;
                word_count <= word_next;
            end
        end
    end
endmodule
